latch_bank_ctrl: RTL and testbench

- Write controller for a shared bank of DEPTH D-latch words, each word being WIDTH level-sensitive latches with one enable.
- Arbitrates two write requesters with round-robin priority.
- Sequences each write as data setup, then enable pulse, then data hold, so latch D never changes while its enable is high.
- Sits between the requesting logic and the latch array; the latch array itself is outside this block.

---
 rtl/latch_bank_ctrl_pkg.sv | 20 ++
 rtl/latch_bank_ctrl_if.sv | 35 +++
 rtl/latch_bank_ctrl_rr_arb2.sv | 41 ++++
 rtl/latch_bank_ctrl.sv | 152 +++++++++++++++
 tb/tb_latch_bank_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/latch_bank_ctrl_pkg.sv
// Shared definitions for the latch bank write controller.
// Holds the FSM state encoding and small sizing helpers.
// No logic lives here.
package latch_bank_ctrl_pkg;

    // Write sequencing states; the encoding is fixed so that debug probes and
    // any later shared-resource blocks agree on the values.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Width of a down-counter that must hold n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Request/ack bus of the two write requesters plus the latch-array drive.
// Pure wiring, no latency.
// Requesters hold req until their ack; the controller paces them.
interface latch_bank_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
);
    logic             req0;
    logic [AW-1:0]    addr0;
    logic [WIDTH-1:0] data0;
    logic             ack0;
    logic             req1;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] data1;
    logic             ack1;
    logic             err;
    logic [WIDTH-1:0] lat_d;
    logic [DEPTH-1:0] lat_en;
    logic             busy;

    // Requester side: drives requests, observes completion and latch drive.
    modport master (
        output req0, addr0, data0,
        output req1, addr1, data1,
        input  ack0, ack1, err, lat_d, lat_en, busy
    );

    // Controller side.
    modport slave (
        input  req0, addr0, data0,
        input  req1, addr1, data1,
        output ack0, ack1, err, lat_d, lat_en, busy
    );
endinterface

// File: rtl/latch_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; gnt is combinational from req and last_grant.
// Latency: zero to grant; last_grant updates on the edge where accept is high.
// No backpressure of its own: the owner decides when a grant is taken via accept.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt0,
    output logic gnt1
);

    // 1 means requester 1 was served last, so requester 0 wins the next tie.
    logic last_grant_q;
    logic last_grant_d;

    // Grant the lone requester, or on a tie the one not served last.
    always_comb begin
        gnt0 = req0 && (!req1 || last_grant_q);
        gnt1 = req1 && (!req0 || !last_grant_q);
    end

    // Remember who won once the grant is actually taken.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept && (gnt0 || gnt1)) begin
            last_grant_d = gnt1;
        end
    end

    // last_grant register; reset favours requester 0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write controller for a bank of level-sensitive latch words, two requesters.
// Latency: grant cycle, 1 SETUP, EN_CYCLES PULSE, 1 HOLD with ack (3+EN_CYCLES).
// Backpressure: requests are only sampled in IDLE; requesters hold req until ack.
module latch_bank_ctrl
    import latch_bank_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int EN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    latch_bank_ctrl_if.slave  bus
);

    localparam int            CW       = cnt_width(EN_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(EN_CYCLES - 1);
    // DEPTH may equal 2**AW, so compare on AW+1 bits.
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             id_q, id_d;
    logic             oob_q, oob_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [DEPTH-1:0] lat_en_q, lat_en_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             gnt0, gnt1;
    logic             accept;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;

    // A grant is taken only from IDLE; requests seen while busy are ignored.
    assign accept   = (state_q == IDLE) && (bus.req0 || bus.req1);
    assign sel_addr = gnt1 ? bus.addr1 : bus.addr0;
    assign sel_data = gnt1 ? bus.data1 : bus.data0;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (bus.req0),
        .req1   (bus.req1),
        .accept (accept),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    // State and captured-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= 1'b0;
            oob_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            oob_q   <= oob_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: capture on grant, then setup, counted pulse, hold.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        oob_d   = oob_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    addr_d  = sel_addr;
                    id_d    = gnt1;
                    oob_d   = ({1'b0, sel_addr} >= DEPTH_W);
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = CNT_LOAD;
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the upcoming state so they line up
    // with it: lat_d loads at the grant edge and is then frozen until the next
    // grant, which keeps D stable for the whole enable window.
    always_comb begin
        lat_d_d  = lat_d_q;
        lat_en_d = '0;
        if (accept) begin
            lat_d_d = sel_data;
        end
        if ((state_d == PULSE) && !oob_q) begin
            lat_en_d = {{(DEPTH-1){1'b0}}, 1'b1} << addr_q;
        end
        ack0_d = (state_d == HOLD) && !id_q;
        ack1_d = (state_d == HOLD) &&  id_q;
        err_d  = (state_d == HOLD) &&  oob_q;
        busy_d = (state_d != IDLE);
    end

    // Output registers; reset drops the enables immediately, mid-write included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_d_q  <= '0;
            lat_en_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.lat_d  = lat_d_q;
    assign bus.lat_en = lat_en_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Directed bench for latch_bank_ctrl: a DEPTH=4 build and a DEPTH=3 build.
// Table of single-write vectors plus hand sequences for multi-cycle cases.
// A free-running checker watches latch-safety invariants on both builds.
module tb_latch_bank_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    latch_bank_ctrl_if #(.WIDTH(8), .DEPTH(4), .AW(2)) bus  ();
    latch_bank_ctrl_if #(.WIDTH(8), .DEPTH(3), .AW(2)) bus3 ();

    latch_bank_ctrl #(.WIDTH(8), .DEPTH(4), .AW(2), .EN_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    latch_bank_ctrl #(.WIDTH(8), .DEPTH(3), .AW(2), .EN_CYCLES(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         sel;      // 0: DEPTH=4 build, 1: DEPTH=3 build
        logic       r0;
        logic [1:0] a0;
        logic [7:0] d0;
        logic       r1;
        logic [1:0] a1;
        logic [7:0] d1;
        bit         exp_id;
        logic [3:0] exp_en;
        logic [7:0] exp_d;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] s_en(input bit sel);
        return sel ? {1'b0, bus3.lat_en} : bus.lat_en;
    endfunction
    function automatic logic [7:0] s_d(input bit sel);
        return sel ? bus3.lat_d : bus.lat_d;
    endfunction
    function automatic logic s_ack0(input bit sel);
        return sel ? bus3.ack0 : bus.ack0;
    endfunction
    function automatic logic s_ack1(input bit sel);
        return sel ? bus3.ack1 : bus.ack1;
    endfunction
    function automatic logic s_err(input bit sel);
        return sel ? bus3.err : bus.err;
    endfunction
    function automatic logic s_busy(input bit sel);
        return sel ? bus3.busy : bus.busy;
    endfunction

    task automatic drive(input bit sel, input logic r0, input logic [1:0] a0, input logic [7:0] d0,
                         input logic r1, input logic [1:0] a1, input logic [7:0] d1);
        if (!sel) begin
            bus.req0 = r0; bus.addr0 = a0; bus.data0 = d0;
            bus.req1 = r1; bus.addr1 = a1; bus.data1 = d1;
        end else begin
            bus3.req0 = r0; bus3.addr0 = a0; bus3.data0 = d0;
            bus3.req1 = r1; bus3.addr1 = a1; bus3.data1 = d1;
        end
    endtask

    // One write: requests drop right after the grant, the write must still finish.
    task automatic run_vec(input vec_t v, input int idx);
        drive(v.sel, v.r0, v.a0, v.d0, v.r1, v.a1, v.d1);
        tick();  // grant edge -> SETUP
        drive(v.sel, 1'b0, v.a0, v.d0, 1'b0, v.a1, v.d1);
        chk($sformatf("v%0d setup busy", idx), s_busy(v.sel), 1);
        chk($sformatf("v%0d setup en", idx), s_en(v.sel), 0);
        chk($sformatf("v%0d setup d", idx), s_d(v.sel), v.exp_d);
        for (int p = 0; p < 2; p++) begin
            tick();
            chk($sformatf("v%0d pulse%0d en", idx, p), s_en(v.sel), v.exp_en);
            chk($sformatf("v%0d pulse%0d d", idx, p), s_d(v.sel), v.exp_d);
            chk($sformatf("v%0d pulse%0d ack", idx, p), {s_ack0(v.sel), s_ack1(v.sel)}, 0);
        end
        tick();  // HOLD
        chk($sformatf("v%0d hold en", idx), s_en(v.sel), 0);
        chk($sformatf("v%0d hold ack0", idx), s_ack0(v.sel), !v.exp_id);
        chk($sformatf("v%0d hold ack1", idx), s_ack1(v.sel), v.exp_id);
        chk($sformatf("v%0d hold err", idx), s_err(v.sel), v.exp_err);
        chk($sformatf("v%0d hold d", idx), s_d(v.sel), v.exp_d);
        tick();  // IDLE
        chk($sformatf("v%0d idle busy", idx), s_busy(v.sel), 0);
        chk($sformatf("v%0d idle ack", idx), {s_ack0(v.sel), s_ack1(v.sel), s_err(v.sel)}, 0);
        chk($sformatf("v%0d idle d kept", idx), s_d(v.sel), v.exp_d);
    endtask

    // Invariants on both builds: enables one-hot or zero, D frozen while enabled,
    // never two acks at once.
    logic [7:0] prev_d, prev_d3;
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (!$onehot0(bus.lat_en) || (bus.lat_en != 0 && bus.lat_d != prev_d) ||
                (bus.ack0 && bus.ack1)) begin
                bad++;
                $display("FAIL inv4: en=%b d=%0h prev_d=%0h acks=%b%b",
                         bus.lat_en, bus.lat_d, prev_d, bus.ack0, bus.ack1);
            end
            total++;
            if (!$onehot0(bus3.lat_en) || (bus3.lat_en != 0 && bus3.lat_d != prev_d3) ||
                (bus3.ack0 && bus3.ack1)) begin
                bad++;
                $display("FAIL inv3: en=%b d=%0h prev_d=%0h acks=%b%b",
                         bus3.lat_en, bus3.lat_d, prev_d3, bus3.ack0, bus3.ack1);
            end
        end
        prev_d  = bus.lat_d;
        prev_d3 = bus3.lat_d;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   ack_id[4];
        int   ack_cyc[4];
        int   n_ack;
        int   idle_cnt;

        // Main-build last_grant after each: 0,1,0,1,0,1 (reset value 1).
        vecs[0] = '{0, 1, 2'd2, 8'hA5, 0, 2'd0, 8'h00, 0, 4'b0100, 8'hA5, 0};
        vecs[1] = '{0, 0, 2'd0, 8'h00, 1, 2'd1, 8'h3C, 1, 4'b0010, 8'h3C, 0};
        vecs[2] = '{0, 1, 2'd0, 8'h11, 1, 2'd3, 8'h22, 0, 4'b0001, 8'h11, 0};
        vecs[3] = '{0, 1, 2'd1, 8'h55, 1, 2'd0, 8'hAA, 1, 4'b0001, 8'hAA, 0};
        vecs[4] = '{0, 1, 2'd3, 8'hFF, 0, 2'd0, 8'h00, 0, 4'b1000, 8'hFF, 0};
        vecs[5] = '{0, 1, 2'd1, 8'h66, 1, 2'd2, 8'h0F, 1, 4'b0100, 8'h0F, 0};
        // DEPTH=3 build: address 3 is out of range, address 2 is the top word.
        vecs[6] = '{1, 0, 2'd0, 8'h00, 1, 2'd3, 8'h77, 1, 4'b0000, 8'h77, 1};
        vecs[7] = '{1, 1, 2'd2, 8'h99, 0, 2'd0, 8'h00, 0, 4'b0100, 8'h99, 0};

        drive(0, 1, 2'd2, 8'hA5, 0, 2'd0, 8'h00);
        drive(1, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
        tick();
        tick();
        // Held in reset with req0 high: everything stays quiet.
        chk("rst en",   bus.lat_en, 0);
        chk("rst d",    bus.lat_d, 0);
        chk("rst acks", {bus.ack0, bus.ack1, bus.err}, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst3 all", {bus3.lat_en, bus3.lat_d, bus3.ack0, bus3.ack1, bus3.err, bus3.busy}, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Both requesters held: grants alternate 0,1,0,1 with one idle cycle between.
        n_ack    = 0;
        idle_cnt = 0;
        drive(0, 1, 2'd1, 8'hC3, 1, 2'd2, 8'h3C);
        for (int c = 0; c < 60 && n_ack < 4; c++) begin
            tick();
            if (n_ack >= 1 && !bus.busy) idle_cnt++;
            if (bus.ack0 || bus.ack1) begin
                ack_id[n_ack]  = bus.ack1 ? 1 : 0;
                ack_cyc[n_ack] = c;
                n_ack++;
                if (n_ack == 4) drive(0, 0, 2'd1, 8'hC3, 0, 2'd2, 8'h3C);
            end
        end
        chk("cont ack count", n_ack, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_ack) chk($sformatf("cont order%0d", k), ack_id[k], k % 2);
            if (k >= 1 && k < n_ack) chk($sformatf("cont gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 5);
        end
        chk("cont idle cycles", idle_cnt, 3);
        tick();
        tick();
        chk("cont drained", bus.busy, 0);

        // Asynchronous reset in the middle of the enable pulse.
        drive(0, 1, 2'd1, 8'h5A, 0, 2'd0, 8'h00);
        tick();
        chk("mid setup d", bus.lat_d, 8'h5A);
        tick();
        chk("mid pulse en", bus.lat_en, 4'b0010);
        #2 rst = 1'b1;
        #1;
        chk("mid async en", bus.lat_en, 0);
        chk("mid async busy", bus.busy, 0);
        chk("mid async d", bus.lat_d, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid rst quiet%0d", k), {bus.ack0, bus.ack1, bus.lat_en}, 0);
        end
        rst = 1'b0;
        rv = '{0, 1, 2'd1, 8'h5A, 0, 2'd0, 8'h00, 0, 4'b0010, 8'h5A, 0};
        run_vec(rv, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
